nf_mem_arb: RTL and testbench

Two-port arbiter sharing the single-port synchronous data RAM of the nanoFOX core between the instruction-fetch port (I) and the load/store port (D). It sequences every access as an address phase followed by a data phase, alternates grants round-robin under contention, returns read data with a one-cycle acknowledge pulse, and keeps per-port saturating wait-cycle counters for debug.

---
 rtl/nf_mem_arb.sv | 110 +++++++++++
 tb/tb_nf_mem_arb.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_mem_arb.sv
// nf_mem_arb: round-robin arbiter sharing the nanoFOX single-port data RAM
// between the instruction-fetch port (I) and the load/store port (D).
module nf_mem_arb #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [AW-1:0]     i_addr,
  output logic [DW-1:0]     i_rd,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DW/8-1:0]   d_be,
  input  logic [AW-1:0]     d_addr,
  input  logic [DW-1:0]     d_wd,
  output logic [DW-1:0]     d_rd,
  output logic              d_ack,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [DW/8-1:0]   mem_be,
  output logic [DW-1:0]     mem_wd,
  input  logic [DW-1:0]     mem_rd,
  output logic [CNT_W-1:0]  i_wait_cnt,
  output logic [CNT_W-1:0]  d_wait_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state, state_nxt;
  logic   own, own_nxt;     // 0 = I, 1 = D
  logic   last, last_nxt;   // port granted most recently
  logic   i_ack_nxt, d_ack_nxt;
  logic   i_busy, d_busy, wr_phase;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      own   <= 1'b0;
      last  <= 1'b0;
      i_ack <= 1'b0;
      d_ack <= 1'b0;
    end else begin
      state <= state_nxt;
      own   <= own_nxt;
      last  <= last_nxt;
      i_ack <= i_ack_nxt;
      d_ack <= d_ack_nxt;
    end
  end

  // Grant selection: in DATA only the non-owner may be granted, so a port
  // holding req through its own ack cannot starve the other one.
  always_comb begin
    state_nxt = state;
    own_nxt   = own;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          own_nxt   = (i_req && d_req) ? ~last : d_req;
          state_nxt = ADDR;
        end
      end
      ADDR: state_nxt = DATA;
      DATA: begin
        last_nxt = own;
        if (own ? i_req : d_req) begin
          own_nxt   = ~own;
          state_nxt = ADDR;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    i_ack_nxt = (state_nxt == DATA) && !own_nxt;
    d_ack_nxt = (state_nxt == DATA) && own_nxt;
  end

  assign i_busy = (state != IDLE) && !own;
  assign d_busy = (state != IDLE) && own;

  // Saturating wait counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      i_wait_cnt <= '0;
      d_wait_cnt <= '0;
    end else begin
      if (i_req && !i_busy && (i_wait_cnt != CNT_MAX))
        i_wait_cnt <= i_wait_cnt + CNT_W'(1);
      if (d_req && !d_busy && (d_wait_cnt != CNT_MAX))
        d_wait_cnt <= d_wait_cnt + CNT_W'(1);
    end
  end

  // A store in ADDR must not reach the RAM on a reset edge.
  assign wr_phase = resetn && (state == ADDR) && own;
  assign mem_addr = own ? d_addr : i_addr;
  assign mem_we   = wr_phase && d_we;
  assign mem_be   = wr_phase ? d_be : '0;
  assign mem_wd   = own ? d_wd : '0;
  assign i_rd     = mem_rd;
  assign d_rd     = mem_rd;

endmodule

// File: tb/tb_nf_mem_arb.sv
// Testbench for nf_mem_arb: timestamp-based transaction model with a byte-merging
// RAM image, plus a CNT_W=4 instance for counter saturation.
module tb_nf_mem_arb;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic clk = 1'b0;
  logic resetn;
  logic i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr, mem_addr, s_mem_addr;
  logic [BW-1:0] d_be, mem_be, s_mem_be;
  logic [DW-1:0] d_wd, i_rd, d_rd, mem_rd, mem_wd, s_i_rd, s_d_rd, s_mem_wd;
  logic i_ack, d_ack, mem_we, s_i_ack, s_d_ack, s_mem_we;
  logic [15:0] i_wait_cnt, d_wait_cnt;
  logic [3:0]  s_i_cnt, s_d_cnt;

  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];

  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  nf_mem_arb #(.AW(AW), .DW(DW), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_rd(i_rd), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wd(d_wd),
    .d_rd(d_rd), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .i_wait_cnt(i_wait_cnt), .d_wait_cnt(d_wait_cnt)
  );

  nf_mem_arb #(.AW(AW), .DW(DW), .CNT_W(4)) dut_sat (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_rd(s_i_rd), .i_ack(s_i_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wd(d_wd),
    .d_rd(s_d_rd), .d_ack(s_d_ack),
    .mem_addr(s_mem_addr), .mem_we(s_mem_we), .mem_be(s_mem_be), .mem_wd(s_mem_wd),
    .mem_rd(mem_rd), .i_wait_cnt(s_i_cnt), .d_wait_cnt(s_d_cnt)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  // Registered single-port RAM, word-indexed by byte address bits [9:2].
  always @(posedge clk) begin
    if (pl_en) ram[pl_idx] <= pl_data;
    else if (mem_we) ram[mem_addr[9:2]] <= merge(ram[mem_addr[9:2]], mem_wd, mem_be);
    mem_rd <= ram[mem_addr[9:2]];
  end

  // Reference model: a transaction occupies cycles start (address) and start+1 (ack).
  int          cyc = 0, m_start = 0;
  bit          m_active = 0, m_owner = 0, m_last = 0, m_is_wr = 0;
  logic [31:0] m_addr = '0;
  int          m_ci = 0, m_cd = 0, m_c4i = 0, m_c4d = 0;
  bit          exp_i_ack, exp_d_ack, exp_we;
  logic [3:0]  exp_be;
  logic [31:0] exp_rd;

  task automatic tick();
    bit fin, gi, gd;
    @(posedge clk);
    cyc++;
    if (!resetn) begin
      m_active = 0; m_last = 0;
      m_ci = 0; m_cd = 0; m_c4i = 0; m_c4d = 0;
    end else begin
      if (i_req && !(m_active && !m_owner)) begin
        if (m_ci < 65535) m_ci++;
        if (m_c4i < 15) m_c4i++;
      end
      if (d_req && !(m_active && m_owner)) begin
        if (m_cd < 65535) m_cd++;
        if (m_c4d < 15) m_c4d++;
      end
      if (m_active && (cyc - 1 == m_start) && m_is_wr)
        ref_mem[m_addr[9:2]] = merge(ref_mem[m_addr[9:2]], d_wd, d_be);
      if (!m_active || (cyc - 1 == m_start + 1)) begin
        fin = m_active;
        if (fin) m_last = m_owner;
        gi = i_req && !(fin && !m_owner);
        gd = d_req && !(fin && m_owner);
        if (gi || gd) begin
          m_owner  = (gi && gd) ? !m_last : gd;
          m_active = 1;
          m_start  = cyc;
          m_addr   = m_owner ? d_addr : i_addr;
          m_is_wr  = m_owner && d_we;
        end else begin
          m_active = 0;
        end
      end
    end
    exp_i_ack = m_active && (cyc == m_start + 1) && !m_owner;
    exp_d_ack = m_active && (cyc == m_start + 1) && m_owner;
    exp_we    = m_active && (cyc == m_start) && m_is_wr;
    exp_be    = (m_active && (cyc == m_start) && m_owner) ? d_be : 4'h0;
    exp_rd    = ref_mem[m_addr[9:2]];
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data; ref_mem[idx] = data;
    tick();
    pl_en = 1'b0;
  endtask

  // Let held requests complete, releasing each on its ack, then settle to idle.
  task automatic drain();
    for (int k = 0; k < 8 && (i_req || d_req); k++) begin
      tick();
      if (exp_i_ack) i_req = 1'b0;
      if (exp_d_ack) d_req = 1'b0;
    end
    d_we = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    logic [31:0] want;
    resetn = 0; i_req = 1; d_req = 1; d_we = 0; d_be = 4'hF;
    i_addr = 32'h104; d_addr = 32'h208;
    repeat (5) begin
      tick();
      nvec++;
      if ({i_ack, d_ack, mem_we} !== 3'b000) begin
        nerr++; $display("FAIL reset_outputs: ack/ack/we got %b want 000", {i_ack, d_ack, mem_we});
      end
      nvec++;
      if (i_wait_cnt !== 16'd0 || d_wait_cnt !== 16'd0 || s_i_cnt !== 4'd0 || s_d_cnt !== 4'd0) begin
        nerr++; $display("FAIL reset_counters: got %0d %0d %0d %0d want 0", i_wait_cnt, d_wait_cnt, s_i_cnt, s_d_cnt);
      end
    end
    resetn = 1;
    tick();
    nvec++;
    if (mem_addr !== 32'h208) begin
      nerr++; $display("FAIL first_grant_d: mem_addr got %h want 00000208", mem_addr);
    end
    tick();
    want = ref_mem[8'h82];
    nvec++;
    if (d_ack !== 1'b1 || i_ack !== 1'b0 || d_rd !== want) begin
      nerr++; $display("FAIL first_d_ack: ack %b%b rd %h want 01 %h", i_ack, d_ack, d_rd, want);
    end
    d_req = 0;
    tick();
    nvec++;
    if (mem_addr !== 32'h104) begin
      nerr++; $display("FAIL then_i_grant: mem_addr got %h want 00000104", mem_addr);
    end
    tick();
    want = ref_mem[8'h41];
    nvec++;
    if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rd !== want) begin
      nerr++; $display("FAIL then_i_ack: ack %b%b rd %h want 10 %h", i_ack, d_ack, i_rd, want);
    end
    i_req = 0;
    tick(); tick();
    nvec++;
    if (i_wait_cnt !== 16'(m_ci) || d_wait_cnt !== 16'(m_cd)) begin
      nerr++; $display("FAIL reset_wait_cnt: got %0d %0d want %0d %0d", i_wait_cnt, d_wait_cnt, m_ci, m_cd);
    end
  endtask

  task automatic test_single_load();
    int lat = 0;
    logic [31:0] rd = '0;
    preload(8'h04, 32'hDEADBEEF);
    d_addr = 32'h10; d_we = 0; d_req = 1;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      tick();
      nvec++;
      if (i_ack !== 1'b0) begin nerr++; $display("FAIL load_i_ack: got %b want 0", i_ack); end
      if (d_ack === 1'b1) begin lat = k; rd = d_rd; end
    end
    d_req = 0;
    nvec++;
    if (lat != 2) begin nerr++; $display("FAIL load_latency: got %0d want 2", lat); end
    nvec++;
    if (rd !== 32'hDEADBEEF) begin nerr++; $display("FAIL load_data: got %h want deadbeef", rd); end
    tick();
    nvec++;
    if (d_ack !== 1'b0) begin nerr++; $display("FAIL load_ack_width: got %b want 0", d_ack); end
    tick();
  endtask

  task automatic test_store_fetch();
    int we_cnt = 0, lat = 0;
    logic [31:0] rd = '0;
    preload(8'h08, 32'hAABBCCDD);
    d_addr = 32'h20; d_we = 1; d_be = 4'b0011; d_wd = 32'h12345678; d_req = 1;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      tick();
      if (mem_we === 1'b1) begin
        we_cnt++;
        nvec++;
        if (mem_be !== 4'b0011 || mem_wd !== 32'h12345678) begin
          nerr++; $display("FAIL store_bus: be %b wd %h want 0011 12345678", mem_be, mem_wd);
        end
      end
      if (d_ack === 1'b1) lat = k;
    end
    d_req = 0; d_we = 0;
    nvec++;
    if (ram[8] !== 32'hAABB5678) begin nerr++; $display("FAIL store_merge: ram got %h want aabb5678", ram[8]); end
    i_addr = 32'h20; i_req = 1; lat = 0;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      tick();
      if (mem_we === 1'b1) we_cnt++;
      if (i_ack === 1'b1) begin lat = k; rd = i_rd; end
    end
    i_req = 0;
    nvec++;
    if (lat != 2 || rd !== 32'hAABB5678) begin
      nerr++; $display("FAIL fetch_after_store: lat %0d rd %h want 2 aabb5678", lat, rd);
    end
    nvec++;
    if (we_cnt != 1) begin nerr++; $display("FAIL store_we_cycles: got %0d want 1", we_cnt); end
    tick(); tick();
  endtask

  task automatic test_contention();
    int ncomp = 0, prev_cyc = 0, pd_i = -1, pi_d = -1;
    bit prev_port = 0;
    i_req = 1; d_req = 1; d_we = 0; i_addr = $urandom; d_addr = $urandom;
    for (int k = 0; k < 40 && ncomp < 8; k++) begin
      tick();
      nvec++;
      if ({i_ack, d_ack} !== {exp_i_ack, exp_d_ack}) begin
        nerr++; $display("FAIL contention_ack: got %b%b want %b%b", i_ack, d_ack, exp_i_ack, exp_d_ack);
      end
      if (i_ack === 1'b1 || d_ack === 1'b1) begin
        if (ncomp > 0) begin
          nvec++;
          if (d_ack === prev_port || cyc - prev_cyc != 2) begin
            nerr++; $display("FAIL contention_alternate: port %b after %b gap %0d want other port gap 2", d_ack, prev_port, cyc - prev_cyc);
          end
        end
        if (d_ack === 1'b1) begin
          nvec++;
          if (d_rd !== ref_mem[d_addr[9:2]]) begin nerr++; $display("FAIL contention_d_rd: got %h want %h", d_rd, ref_mem[d_addr[9:2]]); end
          if (pd_i >= 0) begin
            nvec++;
            if (int'(i_wait_cnt) - pd_i != 2) begin nerr++; $display("FAIL contention_i_wait: delta %0d want 2", int'(i_wait_cnt) - pd_i); end
          end
          pd_i = int'(i_wait_cnt);
        end else begin
          nvec++;
          if (i_rd !== ref_mem[i_addr[9:2]]) begin nerr++; $display("FAIL contention_i_rd: got %h want %h", i_rd, ref_mem[i_addr[9:2]]); end
          if (pi_d >= 0) begin
            nvec++;
            if (int'(d_wait_cnt) - pi_d != 2) begin nerr++; $display("FAIL contention_d_wait: delta %0d want 2", int'(d_wait_cnt) - pi_d); end
          end
          pi_d = int'(d_wait_cnt);
        end
        prev_port = d_ack; prev_cyc = cyc; ncomp++;
      end
      if (exp_i_ack) i_addr = $urandom;
      if (exp_d_ack) d_addr = $urandom;
    end
    nvec++;
    if (ncomp != 8) begin nerr++; $display("FAIL contention_count: got %0d completions want 8", ncomp); end
    drain();
  endtask

  task automatic test_saturation();
    i_req = 1; d_req = 1; d_we = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      nvec++;
      if (s_i_cnt !== 4'(m_c4i) || s_d_cnt !== 4'(m_c4d)) begin
        nerr++; $display("FAIL sat_track: got %0d %0d want %0d %0d", s_i_cnt, s_d_cnt, m_c4i, m_c4d);
      end
      if (exp_i_ack) i_addr = $urandom;
      if (exp_d_ack) d_addr = $urandom;
    end
    nvec++;
    if (s_i_cnt !== 4'd15) begin nerr++; $display("FAIL sat_i_stuck: got %0d want 15", s_i_cnt); end
    nvec++;
    if (i_wait_cnt !== 16'(m_ci)) begin nerr++; $display("FAIL sat_wide_cnt: got %0d want %0d", i_wait_cnt, m_ci); end
    drain();
  endtask

  task automatic test_mid_reset();
    logic [31:0] old;
    d_addr = 32'h30; d_we = 0; d_req = 1;
    tick();
    nvec++;
    if (mem_addr !== 32'h30) begin nerr++; $display("FAIL midrst_addr: got %h want 00000030", mem_addr); end
    resetn = 0;
    tick();
    nvec++;
    if (d_ack !== 1'b0 || i_ack !== 1'b0) begin nerr++; $display("FAIL midrst_no_ack: got %b%b want 00", i_ack, d_ack); end
    nvec++;
    if (d_wait_cnt !== 16'd0 || s_d_cnt !== 4'd0) begin nerr++; $display("FAIL midrst_cnt: got %0d %0d want 0", d_wait_cnt, s_d_cnt); end
    resetn = 1;
    tick();
    nvec++;
    if (d_ack !== 1'b0 || mem_addr !== 32'h30) begin nerr++; $display("FAIL midrst_regrant: ack %b addr %h want 0 00000030", d_ack, mem_addr); end
    tick();
    nvec++;
    if (d_ack !== 1'b1 || d_rd !== ref_mem[8'h0C]) begin
      nerr++; $display("FAIL midrst_complete: ack %b rd %h want 1 %h", d_ack, d_rd, ref_mem[8'h0C]);
    end
    d_req = 0;
    tick(); tick();
    old = ref_mem[8'h10];
    d_addr = 32'h40; d_we = 1; d_be = 4'hF; d_wd = ~old; d_req = 1;
    tick();
    resetn = 0;
    #1;
    nvec++;
    if (mem_we !== 1'b0) begin nerr++; $display("FAIL abort_store_we: got %b want 0", mem_we); end
    tick();
    d_req = 0; d_we = 0; resetn = 1;
    tick(); tick();
    nvec++;
    if (ram[16] !== old) begin nerr++; $display("FAIL abort_store_ram: got %h want %h", ram[16], old); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      tick();
      nvec++;
      if ({i_ack, d_ack, s_i_ack, s_d_ack} !== {exp_i_ack, exp_d_ack, exp_i_ack, exp_d_ack}) begin
        nerr++; $display("FAIL rand_ack: got %b%b/%b%b want %b%b", i_ack, d_ack, s_i_ack, s_d_ack, exp_i_ack, exp_d_ack);
      end
      nvec++;
      if (mem_we !== exp_we || s_mem_we !== exp_we || mem_be !== exp_be) begin
        nerr++; $display("FAIL rand_we: we %b/%b be %b want %b %b", mem_we, s_mem_we, mem_be, exp_we, exp_be);
      end
      if (m_active && cyc == m_start) begin
        nvec++;
        if (mem_addr !== m_addr || s_mem_addr !== m_addr) begin
          nerr++; $display("FAIL rand_addr: got %h/%h want %h", mem_addr, s_mem_addr, m_addr);
        end
      end
      if (exp_i_ack) begin
        nvec++;
        if (i_rd !== exp_rd) begin nerr++; $display("FAIL rand_i_rd: got %h want %h", i_rd, exp_rd); end
      end
      if (exp_d_ack && !m_is_wr) begin
        nvec++;
        if (d_rd !== exp_rd) begin nerr++; $display("FAIL rand_d_rd: got %h want %h", d_rd, exp_rd); end
      end
      nvec++;
      if (i_wait_cnt !== 16'(m_ci) || d_wait_cnt !== 16'(m_cd) ||
          s_i_cnt !== 4'(m_c4i) || s_d_cnt !== 4'(m_c4d)) begin
        nerr++; $display("FAIL rand_cnt: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                         i_wait_cnt, d_wait_cnt, s_i_cnt, s_d_cnt, m_ci, m_cd, m_c4i, m_c4d);
      end
      if (!i_req || exp_i_ack) begin
        i_req = ($urandom_range(0, 99) < 55); i_addr = $urandom;
      end
      if (!d_req || exp_d_ack) begin
        d_req = ($urandom_range(0, 99) < 55); d_addr = $urandom;
        d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom); d_wd = $urandom;
      end
    end
    drain();
  endtask

  initial begin
    resetn = 0; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_be = '0; d_wd = '0;
    pl_en = 0; pl_idx = '0; pl_data = '0;
    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
    test_reset();
    test_single_load();
    test_store_fetch();
    test_contention();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
